// File: rtl/spec_counter_pkg.sv
// Shared types and default parameters for the push-button counter with LED readout.
package spec_counter_pkg;

  typedef enum logic [1:0] {
    STEP  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Debug view of the control path, exported through the interface.
  typedef struct packed {
    state_t state;
    logic   clear_pressed;
    logic   count_pressed;
    logic   clear_event;
    logic   count_event;
  } dbg_t;

  localparam int DEF_WIDTH           = 8;
  localparam int DEF_LED_COUNT       = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_PRESCALE        = 20000000;

endpackage

// File: rtl/spec_counter_led_if.sv
// Board-facing signals of the counter: raw buttons/switches in, counter, LEDs and status out.
// Inputs are plain levels with no handshake; the master side drives them and samples the outputs.
interface spec_counter_led_if
  import spec_counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int LED_COUNT = DEF_LED_COUNT
) ();

  logic                 clear_i;
  logic                 count_i;
  logic                 mode_i;
  logic                 dir_i;
  logic [WIDTH-1:0]     count_o;
  logic [LED_COUNT-1:0] led_o;
  logic                 run_o;
  dbg_t                 dbg;

  modport master (
    output clear_i, count_i, mode_i, dir_i,
    input  count_o, led_o, run_o, dbg
  );

  modport slave (
    input  clear_i, count_i, mode_i, dir_i,
    output count_o, led_o, run_o, dbg
  );

endinterface

// File: rtl/spec_counter_led_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stability counter, debounced level
// and a single-cycle press pulse on the released->pressed transition.
module button_debounce
  import spec_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic button_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic [CW-1:0] stable_cnt_q;
  logic          level_q;
  logic          prev_q;
  logic          armed_q;
  logic          press_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q       <= 2'b11;
      fill_q       <= 2'b00;
      stable_cnt_q <= '0;
      level_q      <= 1'b1;
      prev_q       <= 1'b1;
      armed_q      <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_i};
      fill_q <= {fill_q[0], 1'b1};
      // A button held through reset must be seen released before it may raise an event.
      if (fill_q[1] && sync_q[1]) armed_q <= 1'b1;
      if (sync_q[1] != level_q) begin
        if (stable_cnt_q == CNT_MAX) begin
          level_q      <= sync_q[1];
          stable_cnt_q <= '0;
        end else begin
          stable_cnt_q <= stable_cnt_q + CW'(1);
        end
      end else begin
        stable_cnt_q <= '0;
      end
      prev_q  <= level_q;
      press_q <= armed_q & prev_q & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/spec_counter_led.sv
// Step / free-run up-down counter driven by debounced push-buttons, with an active-low
// LED view of the counter's top bits.
module spec_counter_led
  import spec_counter_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int LED_COUNT       = DEF_LED_COUNT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PRESCALE        = DEF_PRESCALE
) (
  input  logic               clock_i,
  input  logic               reset_i,
  spec_counter_led_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic clear_level, clear_press, count_level, count_press;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .button_i(bus.clear_i),
    .level_o (clear_level),
    .press_o (clear_press)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_count_db (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .button_i(bus.count_i),
    .level_o (count_level),
    .press_o (count_press)
  );

  logic [1:0]           mode_sync_q, dir_sync_q;
  state_t               state_q;
  logic                 run_q;
  logic [PW-1:0]        presc_q;
  logic [WIDTH-1:0]     count_q;
  logic [LED_COUNT-1:0] led_q;
  logic                 mode_s, dir_s, clear_hold, tick, step;

  assign mode_s     = mode_sync_q[1];
  assign dir_s      = dir_sync_q[1];
  assign clear_hold = ~clear_level;
  assign tick       = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign step       = tick || ((state_q == STEP) && count_press);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mode_sync_q <= 2'b00;
      dir_sync_q  <= 2'b11;
    end else begin
      mode_sync_q <= {mode_sync_q[0], bus.mode_i};
      dir_sync_q  <= {dir_sync_q[0], bus.dir_i};
    end
  end

  // Leaving free-run via the mode switch wins over any press in the same cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= STEP;
      run_q   <= 1'b0;
    end else if (!mode_s) begin
      state_q <= STEP;
      run_q   <= 1'b0;
    end else begin
      case (state_q)
        STEP: begin
          state_q <= RUN;
          run_q   <= 1'b1;
        end
        RUN: if (count_press) begin
          state_q <= PAUSE;
          run_q   <= 1'b0;
        end
        PAUSE: if (count_press) begin
          state_q <= RUN;
          run_q   <= 1'b1;
        end
        default: begin
          state_q <= STEP;
          run_q   <= 1'b0;
        end
      endcase
    end
  end

  // A held clear pins counter and prescaler at zero without disturbing the state machine.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      presc_q <= '0;
      count_q <= '0;
      led_q   <= '1;
    end else begin
      led_q <= ~count_q[WIDTH-1 -: LED_COUNT];
      if (clear_hold) begin
        presc_q <= '0;
        count_q <= '0;
      end else begin
        if (step) count_q <= dir_s ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        case (state_q)
          RUN:     presc_q <= tick ? '0 : presc_q + PW'(1);
          STEP:    presc_q <= '0;
          default: presc_q <= presc_q;
        endcase
      end
    end
  end

  assign bus.count_o = count_q;
  assign bus.led_o   = led_q;
  assign bus.run_o   = run_q;

  assign bus.dbg.state         = state_q;
  assign bus.dbg.clear_pressed = ~clear_level;
  assign bus.dbg.count_pressed = ~count_level;
  assign bus.dbg.clear_event   = clear_press;
  assign bus.dbg.count_event   = count_press;

endmodule

// File: tb/tb_spec_counter_led.sv
// Bench for spec_counter_led: a pin-history model predicts count/led/run every cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_spec_counter_led;
  import spec_counter_pkg::*;

  localparam int WIDTH     = 8;
  localparam int LED_COUNT = 4;
  localparam int DB        = 4;
  localparam int PS        = 3;
  localparam int EW        = 1 + LED_COUNT + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spec_counter_led_if #(.WIDTH(WIDTH), .LED_COUNT(LED_COUNT)) bus ();

  spec_counter_led #(
    .WIDTH(WIDTH), .LED_COUNT(LED_COUNT), .DEBOUNCE_CYCLES(DB), .PRESCALE(PS)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pin samples since the last reset, one per rising edge; a sample is seen by the
  // logic two edges later (synchronizer depth).
  bit h_cnt[$], h_clr[$], h_mode[$], h_dir[$];
  logic [EW-1:0] exp_q[$];

  int         m_state;   // 0 = step, 1 = run, 2 = pause
  int         m_presc;
  logic [7:0] m_count;
  logic [3:0] m_led;
  bit         m_run, m_cnt_lvl, m_clr_lvl, m_rel_seen, m_pend, m_pulse;

  // True when the last DB synchronized samples all disagree with the accepted level.
  function automatic bit opposed(input bit q[$], input int e, input bit lvl);
    for (int i = 0; i < DB; i++) begin
      int k;
      bit s;
      k = e - 2 - i;
      s = (k < 0) ? 1'b1 : q[k];
      if (s == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h_cnt.delete(); h_clr.delete(); h_mode.delete(); h_dir.delete();
      m_state = 0; m_presc = 0; m_count = 8'h00; m_led = 4'hF; m_run = 1'b0;
      m_cnt_lvl = 1'b1; m_clr_lvl = 1'b1; m_rel_seen = 1'b0; m_pend = 1'b0; m_pulse = 1'b0;
    end else begin
      int e;
      bit mode_s, dir_s, press_now, clr_hold, flip, tick, stepping;
      h_cnt.push_back(bus.count_i);
      h_clr.push_back(bus.clear_i);
      h_mode.push_back(bus.mode_i);
      h_dir.push_back(bus.dir_i);
      e = h_cnt.size() - 1;
      mode_s    = (e >= 2) ? h_mode[e-2] : 1'b0;
      dir_s     = (e >= 2) ? h_dir[e-2]  : 1'b1;
      press_now = m_pulse;
      clr_hold  = !m_clr_lvl;
      if (e >= 2 && h_cnt[e-2]) m_rel_seen = 1'b1;
      flip    = opposed(h_cnt, e, m_cnt_lvl);
      m_pulse = m_pend;
      m_pend  = flip && m_cnt_lvl && m_rel_seen;
      if (flip) m_cnt_lvl = !m_cnt_lvl;
      if (opposed(h_clr, e, m_clr_lvl)) m_clr_lvl = !m_clr_lvl;

      tick     = (m_state == 1) && (m_presc == PS - 1);
      stepping = tick || (m_state == 0 && press_now);
      m_led    = ~m_count[7:4];
      if (clr_hold) begin
        m_count = 8'h00;
        m_presc = 0;
      end else begin
        if (stepping) m_count = dir_s ? m_count + 8'd1 : m_count - 8'd1;
        if (m_state == 1) m_presc = (m_presc + 1) % PS;
        else if (m_state == 0) m_presc = 0;
      end
      if (!mode_s) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (press_now) m_state = (m_state == 1) ? 2 : 1;
      m_run = (m_state == 1);
    end
    exp_q.push_back({m_run, m_led, m_count});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] exp_v;
      exp_v = exp_q.pop_front();
      check("model_count", 32'(bus.count_o), 32'(exp_v[7:0]));
      check("model_led",   32'(bus.led_o),   32'(exp_v[11:8]));
      check("model_run",   32'(bus.run_o),   32'(exp_v[12]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_count();
    bus.count_i = 1'b0;
    wait_cycles(8);
    bus.count_i = 1'b1;
    wait_cycles(8);
  endtask

  task automatic press_clear();
    bus.clear_i = 1'b0;
    wait_cycles(8);
    bus.clear_i = 1'b1;
    wait_cycles(8);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bit found;
    bus.clear_i = 1'b1;
    bus.count_i = 1'b1;
    bus.mode_i  = 1'b0;
    bus.dir_i   = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    check("reset_count", 32'(bus.count_o), 32'h00);
    check("reset_led",   32'(bus.led_o),   32'hF);
    check("reset_run",   32'(bus.run_o),   32'h0);
    check("reset_state", 32'(bus.dbg.state), 32'(STEP));
    rst = 1'b0;
    wait_cycles(6);

    // Clean press: count changes on the 8th rising edge after the pin falls.
    bus.count_i = 1'b0;
    wait_cycles(7);
    check("press_before_latency", 32'(bus.count_o), 32'h00);
    wait_cycles(1);
    check("press_at_latency", 32'(bus.count_o), 32'h01);
    check("press_led", 32'(bus.led_o), 32'hF);
    wait_cycles(2);
    bus.count_i = 1'b1;
    wait_cycles(10);
    check("press_single_inc", 32'(bus.count_o), 32'h01);

    // Short glitch is ignored.
    bus.count_i = 1'b0;
    wait_cycles(2);
    bus.count_i = 1'b1;
    wait_cycles(12);
    check("glitch_ignored", 32'(bus.count_o), 32'h01);

    // Wrap down and back up.
    press_clear();
    check("clear_to_zero", 32'(bus.count_o), 32'h00);
    bus.dir_i = 1'b0;
    press_count();
    check("wrap_down_count", 32'(bus.count_o), 32'hFF);
    check("wrap_down_led",   32'(bus.led_o),   32'h0);
    bus.dir_i = 1'b1;
    press_count();
    check("wrap_up_count", 32'(bus.count_o), 32'h00);
    check("wrap_up_led",   32'(bus.led_o),   32'hF);

    // Free-run: enters RUN two edges after the switch, ticks every 3 cycles.
    bus.mode_i = 1'b1;
    wait_cycles(6);
    check("run_entered", 32'(bus.run_o), 32'h1);
    check("run_first_tick", 32'(bus.count_o), 32'h01);
    wait_cycles(9);
    check("run_fourth_tick", 32'(bus.count_o), 32'h04);
    press_count();
    check("pause_run_low", 32'(bus.run_o), 32'h0);
    check("pause_state", 32'(bus.dbg.state), 32'(PAUSE));
    wait_cycles(6);
    press_count();
    check("resume_run_high", 32'(bus.run_o), 32'h1);

    // Clear lands on the tick that would take 8'h10 to 8'h11.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (m_state == 1 && m_count == 8'h0E && m_presc == PS - 1) found = 1'b1;
      else @(negedge clk);
    end
    check("clear_setup_reached", 32'(found), 32'h1);
    bus.clear_i = 1'b0;
    wait_cycles(6);
    check("clear_pre_value", 32'(bus.count_o), 32'h10);
    wait_cycles(1);
    check("clear_on_tick", 32'(bus.count_o), 32'h00);
    wait_cycles(9);
    check("clear_held_zero", 32'(bus.count_o), 32'h00);
    check("clear_state_run", 32'(bus.dbg.state), 32'(RUN));
    check("clear_run_high", 32'(bus.run_o), 32'h1);
    bus.clear_i = 1'b1;
    wait_cycles(10);

    // Reset mid-debounce with the button still held: no event until released and re-pressed.
    bus.mode_i = 1'b0;
    wait_cycles(4);
    bus.count_i = 1'b0;
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(15);
    check("reset_held_no_event", 32'(bus.count_o), 32'h00);
    bus.count_i = 1'b1;
    wait_cycles(10);
    check("reset_release_no_event", 32'(bus.count_o), 32'h00);
    press_count();
    check("reset_repress_inc", 32'(bus.count_o), 32'h01);

    wait_cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/spec_counter_led.md
SPEC_COUNTER_LED -- requirements
Module: spec_counter_led

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits.
REQ-002 Parameter LED_COUNT, default 4, number of LED outputs; SHALL satisfy 1 <= LED_COUNT <= WIDTH.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a button level; >= 1.
REQ-004 Parameter PRESCALE, default 20000000, clock cycles per free-run tick; >= 1.
REQ-005 clock_i  input  1  single system clock; all logic SHALL be rising-edge clocked on it.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 clear_i  input  1  clear push-button, active-low, asynchronous to clock_i.
REQ-008 count_i  input  1  count push-button, active-low, asynchronous to clock_i.
REQ-009 mode_i  input  1  slide switch: 0 = step mode, 1 = free-run mode; asynchronous.
REQ-010 dir_i  input  1  slide switch: 1 = count up, 0 = count down; asynchronous.
REQ-011 count_o  output  WIDTH  current counter value, registered.
REQ-012 led_o  output  LED_COUNT  active-low LEDs, registered.
REQ-013 run_o  output  1  high while the state machine is in RUN.

Function
REQ-014 clear_i, count_i, mode_i and dir_i SHALL each pass through a 2-flop synchronizer before use.
REQ-015 clear_i and count_i SHALL each be debounced: debounced level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; shorter glitches SHALL have no effect.
REQ-016 A press event SHALL be a single-cycle pulse generated when the debounced count level goes released->pressed; release SHALL generate no event.
REQ-017 State machine states STEP, RUN, PAUSE: any state -> STEP when synchronized mode_i = 0; STEP -> RUN when mode_i = 1; RUN -> PAUSE on press event; PAUSE -> RUN on press event.
REQ-018 In STEP, each press event SHALL change the counter by exactly one step, applied on the cycle after the event.
REQ-019 Prescaler SHALL count 0..PRESCALE-1 only in RUN and emit a tick on reaching PRESCALE-1; each tick changes the counter by one step; prescaler SHALL hold in PAUSE and be zeroed on entry to STEP.
REQ-020 Step direction: +1 when synchronized dir_i = 1, -1 otherwise; arithmetic modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).
REQ-021 While debounced clear is pressed, counter and prescaler SHALL be held at 0; clear SHALL take priority over a simultaneous press event or tick; clear SHALL not change FSM state.
REQ-022 led_o SHALL equal the bitwise inverse of count_o[WIDTH-1 : WIDTH-LED_COUNT], updated one cycle after count_o.
REQ-023 Latency from a clean count_i press at the pin to count_o change in STEP SHALL be DEBOUNCE_CYCLES + 4 cycles (2 sync, debounce, event, update).
REQ-024 A mode_i change to 0 while RUN or PAUSE SHALL take effect on the cycle after the synchronized value changes; the counter value SHALL be retained.

Reset
REQ-025 On reset_i high at a clock edge: count_o = 0, led_o = all ones (LEDs off), run_o = 0, state = STEP, prescaler = 0.
REQ-026 Synchronizer and debounce registers SHALL reset to the released level (1); debounce counters to 0; no press event SHALL be generated on reset exit even if a button is held.
REQ-027 Reset SHALL take priority over every other input, including mid-debounce and mid-prescale.

Structure
REQ-028 Package spec_counter_pkg SHALL hold the FSM state type (STEP, RUN, PAUSE) and default parameter constants.
REQ-029 Debouncing SHALL be one reusable sub-module, button_debounce (synchronizer, stability counter, debounced level, press pulse), instantiated twice.

Verification (WIDTH=8, LED_COUNT=4, DEBOUNCE_CYCLES=4, PRESCALE=3)
REQ-030 Reset, then count_i low 10 cycles -> count_o 0->1 exactly 8 cycles after the falling edge; led_o = 4'b1111; only one increment.
REQ-031 count_i low 2 cycles then high -> no change to count_o.
REQ-032 STEP, dir_i=0, count_o=0, one press -> count_o = 8'hFF, led_o = 4'b0000; dir_i=1, one press -> count_o = 0.
REQ-033 mode_i=1 -> run_o=1, count_o increments every 3 cycles; press -> run_o=0 and count_o frozen; second press -> counting resumes.
REQ-034 RUN with count_o=8'h10, clear_i held low coinciding with a tick -> count_o = 0 and stays 0 while held; state stays RUN.
REQ-035 reset_i asserted mid-debounce with count_i held low, released with count_i still low -> count_o = 0, no increment until released and pressed again.
